// File: rtl/clk_div_prog_pkg.sv
// Shared helpers for the programmable clock divider: ratio clamping and high-time math.
package clk_div_pkg;

  localparam logic [31:0] MIN_DIV = 32'd2;

  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

  // ceil(N/2): odd ratios spend the extra cycle high
  function automatic logic [31:0] high_time(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: square wave on out, period-start strobe on tick.
// New ratios are staged in a shadow register and only take effect at a period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             out,
  output logic             tick,
  output logic [CNT_W-1:0] div_act,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_q, act_q, shadow_q;
  logic             out_q, tick_q, pend_q;

  logic [CNT_W-1:0] cnt_d, act_d, load_n, new_n;
  logic             wrap, apply, out_d;

  assign load_n = CNT_W'(clamp_div(32'(div_val)));

  always_comb begin
    wrap  = (cnt_q == act_q - CNT_W'(1));
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    // a load arriving on the wrap edge bypasses the shadow and applies at once
    new_n = div_load ? load_n : shadow_q;
    apply = en && wrap && (pend_q || div_load);
    act_d = apply ? new_n : act_q;
    // duty is judged against the ratio governing the period cnt_d belongs to
    out_d = (32'(cnt_d) < high_time(32'(act_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= CNT_W'(DEFAULT_DIV - 1);
      act_q    <= CNT_W'(DEFAULT_DIV);
      shadow_q <= CNT_W'(DEFAULT_DIV);
      out_q    <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      if (div_load) shadow_q <= load_n;
      if (apply)         pend_q <= 1'b0;
      else if (div_load) pend_q <= 1'b1;
      if (en) begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        out_q  <= out_d;
        tick_q <= wrap;
      end else begin
        tick_q <= 1'b0;
      end
    end
  end

  assign out     = out_q;
  assign tick    = tick_q;
  assign div_act = act_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed vector bench for clk_div_prog: one table row per clock edge plus async-reset sequence.
module tb_clk_div_prog;

  localparam int CNT_W = 8;

  typedef struct {
    logic             en;
    logic [CNT_W-1:0] val;
    logic             load;
    logic             out;
    logic             tick;
    logic [CNT_W-1:0] act;
    logic             pend;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             out, tick, pending;
  logic [CNT_W-1:0] div_act;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .out(out), .tick(tick), .div_act(div_act), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic o, input logic t,
                         input logic [CNT_W-1:0] a, input logic p);
    chk({nm, ".out"}, 32'(out), 32'(o));
    chk({nm, ".tick"}, 32'(tick), 32'(t));
    chk({nm, ".div_act"}, 32'(div_act), 32'(a));
    chk({nm, ".pending"}, 32'(pending), 32'(p));
  endtask

  task automatic step(input logic e, input logic [CNT_W-1:0] v, input logic l);
    en = e; div_val = v; div_load = l;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input int v, input logic l,
                     input logic o, input logic t, input int a, input logic p);
    vq.push_back('{en: e, val: CNT_W'(v), load: l, out: o, tick: t, act: CNT_W'(a), pend: p});
  endtask

  initial begin
    // edges 1-10: default N=4, then load 5 mid-period
    add(1,0,0, 1,1,4,0); add(1,5,1, 1,0,4,1); add(1,0,0, 0,0,4,1); add(1,0,0, 0,0,4,1);
    add(1,0,0, 1,1,5,0); add(1,0,0, 1,0,5,0); add(1,0,0, 1,0,5,0); add(1,0,0, 0,0,5,0);
    add(1,0,0, 0,0,5,0); add(1,0,0, 1,1,5,0);
    // 11-19: load 1 then 0, clamps to 2
    add(1,1,1, 1,0,5,1); add(1,0,1, 1,0,5,1); add(1,0,0, 0,0,5,1); add(1,0,0, 0,0,5,1);
    add(1,0,0, 1,1,2,0); add(1,0,0, 0,0,2,0); add(1,0,0, 1,1,2,0); add(1,0,0, 0,0,2,0);
    add(1,0,0, 1,1,2,0);
    // 20-31: back to 4, then load 3 exactly on the wrap edge
    add(1,4,1, 0,0,2,1); add(1,0,0, 1,1,4,0); add(1,0,0, 1,0,4,0); add(1,0,0, 0,0,4,0);
    add(1,0,0, 0,0,4,0); add(1,3,1, 1,1,3,0); add(1,0,0, 1,0,3,0); add(1,0,0, 0,0,3,0);
    add(1,0,0, 1,1,3,0); add(1,0,0, 1,0,3,0); add(1,0,0, 0,0,3,0); add(1,0,0, 1,1,3,0);
    // 32-34: reload current ratio
    add(1,3,1, 1,0,3,1); add(1,0,0, 0,0,3,1); add(1,0,0, 1,1,3,0);
    // 35-48: N=6 with a 3-cycle en=0 freeze and a load made while frozen
    add(1,6,1, 1,0,3,1); add(1,0,0, 0,0,3,1); add(1,0,0, 1,1,6,0); add(1,0,0, 1,0,6,0);
    add(0,0,0, 1,0,6,0); add(0,2,1, 1,0,6,1); add(0,0,0, 1,0,6,1); add(1,0,0, 1,0,6,1);
    add(1,0,0, 0,0,6,1); add(1,0,0, 0,0,6,1); add(1,0,0, 0,0,6,1); add(1,0,0, 1,1,2,0);
    add(1,0,0, 0,0,2,0); add(1,0,0, 1,1,2,0);

    rst = 1'b1; en = 1'b0; div_val = '0; div_load = 1'b0;
    #12;
    chk_all("reset", 0, 0, 4, 0);
    rst = 1'b0;
    step(0, 0, 0);
    chk_all("idle_after_reset", 0, 0, 4, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].en, vq[i].val, vq[i].load);
      chk_all($sformatf("edge%0d", i + 1), vq[i].out, vq[i].tick, vq[i].act, vq[i].pend);
    end

    // frozen with out high and a load pending, then async reset between edges
    step(0, 8'd5, 1);
    chk_all("pre_rst", 1, 0, 2, 1);
    en = 1'b0; div_load = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 0, 0, 4, 0);
    #2 rst = 1'b0;
    step(1, 0, 0);
    chk_all("post_rst_e1", 1, 1, 4, 0);
    step(1, 0, 0);
    chk_all("post_rst_e2", 1, 0, 4, 0);
    step(1, 0, 0);
    chk_all("post_rst_e3", 0, 0, 4, 0);
    step(1, 0, 0);
    chk_all("post_rst_e4", 0, 0, 4, 0);
    step(1, 0, 0);
    chk_all("post_rst_e5", 1, 1, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Fully synchronous, runtime-programmable integer clock divider. Successor to the fixed ripple divide-by-4.
- Single clock domain, no derived clocks feeding flops. Produces a square-wave `out` of period N input cycles and a one-cycle `tick` strobe at each period start.
- Downstream logic uses `tick` as a clock enable. `out` is for pins and observation.
- N is reprogrammable at runtime, glitch-free, applied only at period boundaries.

Parameters:
- CNT_W, 8, width of divide value and internal counter; legal range ≥ 2.
- DEFAULT_DIV, 4, divide ratio after reset; legal range 2 .. 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all flops on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; 0 freezes the divider.
- div_val  in  CNT_W  requested divide ratio N.
- div_load  in  1  one-cycle strobe; captures div_val into the shadow register.
- out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse on the cycle `out` rises, registered.
- div_act  out  CNT_W  ratio currently in effect.
- pending  out  1  a loaded ratio is waiting for the next period boundary.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
- Reset values:
  - out=0, tick=0, pending=0.
  - div_act=DEFAULT_DIV, shadow=DEFAULT_DIV.
  - cnt=DEFAULT_DIV-1, so the first enabled edge starts a period.
- Clamping: N = max(value, 2). A div_val of 0 or 1 is stored as 2. No error flag.
- High time: H = (N+1)>>1, i.e. ceil(N/2). Low time = N-H.
  - Even N gives 50% duty.
  - Odd N is high one cycle longer than low (N=5: 3 high, 2 low).
- Per enabled edge (en=1):
  - wrap = (cnt == div_act-1).
  - cnt_nxt = wrap ? 0 : cnt+1.
  - On wrap with pending=1, or with div_load=1 in the same cycle: div_act <= new N, pending <= 0.
  - H is evaluated against the div_act in effect for cnt_nxt, so the new ratio governs the whole new period.
  - out <= (cnt_nxt < H). tick <= wrap.
- Latency:
  - First enabled edge after reset release: out=1, tick=1.
  - Then out falls after H edges and rises again after N edges. Period is exactly N cycles.
- en=0: cnt, out and div_act hold; tick forced 0 on that edge. Resuming continues the same period with no phase loss.
- div_load:
  - Captures clamp(div_val) into shadow; pending <= 1 unless applied in the same cycle.
  - Repeated loads before a boundary: last one wins.
  - Load while en=0: held pending until a wrap occurs with en=1.
- Load coincident with wrap: applied at this wrap. pending stays 0 and the new period uses the new N.
- Loading the current N still sets pending and still "applies" at the wrap; no visible change.
- Glitch-free: out never changes mid-period because of a load. The period in progress always completes with the old N and old H.
- cnt never exceeds div_act-1. The counter wraps at div_act-1, not at 2^CNT_W-1.
- Reset mid-period: immediate asynchronous return to reset values; any pending load is discarded.
- All outputs come straight from flops; no combinational path from input to output.

Decomposition:
- Package clk_div_pkg:
  - Function clamp_div(value) returning max(value, 2).
  - Function high_time(N) returning (N+1)>>1.
  - Constant MIN_DIV = 2.
- No sub-module. Counter, shadow register and output flops live in one always_ff plus a small always_comb for cnt_nxt and the load-apply decision.

Test Plan:
- Reset, en=1, default N=4 → out pattern 1,1,0,0 repeating from edge 1; tick high on edges 1, 5, 9; div_act=4.
- Load div_val=5 at edge 2 → pending=1 until edge 5. Edges 5–9 out = 1,1,1,0,0; tick at edges 5 and 10; div_act=5 from edge 5.
- Load div_val=1 then div_val=0 before a boundary → div_act becomes 2; out toggles every cycle; tick every 2nd cycle.
- Load div_val=3 on the exact wrap edge with N=4 → applied immediately; pending never asserts; next periods are 3 cycles with out 1,1,0.
- en=0 for 3 cycles mid-period with N=6 → out and cnt frozen, tick=0. Period completes after en returns with 6 total enabled edges. A load made during en=0 stays pending until that wrap.
- rst asserted mid-period with pending=1 → out=0, tick=0, pending=0, div_act=DEFAULT_DIV asynchronously. The first enabled edge after release gives out=1, tick=1.
